data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 151 +++++++++++++++
 tb/tb_data_mem_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data memory responder: serves CPU loads/stores with a fixed number of wait states,
// flags misaligned/out-of-range accesses and counts completed good reads and writes.
module data_mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_data,
    input  logic [31:0] data_in,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] data_out,
    output logic        mem_ready,
    output logic        addr_error,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [1:0] WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} state_t;

    state_t      state_q, state_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_write_q, is_write_d;
    logic [31:0] data_out_q, data_out_d;
    logic        err_q, err_d;
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    logic [31:0] mem [DEPTH];

    logic                  request;
    logic                  commit;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_data;
    logic                  acc_write;
    logic                  acc_err;
    logic [DEPTH_LOG2-1:0] acc_index;
    logic                  mem_we;

    assign request = MemRead | MemWrite;

    // The access is committed on the edge entering DONE; with no wait states that is the
    // sampling edge itself, so the live inputs are used instead of the latched copies.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        commit     = 1'b0;
        acc_addr   = addr_q;
        acc_data   = wdata_q;
        acc_write  = is_write_q;
        case (state_q)
            IDLE: begin
                if (request) begin
                    addr_d     = address_data;
                    wdata_d    = data_in;
                    is_write_d = MemWrite;
                    acc_addr   = address_data;
                    acc_data   = data_in;
                    acc_write  = MemWrite;
                    if (WAIT_STATES > 0) begin
                        state_d    = WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == 2'd0) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
            DONE:    state_d = HOLD;
            HOLD:    if (!request) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign acc_index = acc_addr[DEPTH_LOG2+1:2];
    assign mem_we    = commit && acc_write && !acc_err;

    always_comb begin
        data_out_d = data_out_q;
        err_d      = err_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (commit) begin
            err_d = acc_err;
            if (acc_err) begin
                if (!acc_write) data_out_d = 32'h0000_0000;
            end else if (acc_write) begin
                if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
            end else begin
                data_out_d = mem[acc_index];
                if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            is_write_q <= 1'b0;
            data_out_q <= 32'd0;
            err_q      <= 1'b0;
            rd_count_q <= 16'd0;
            wr_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            data_out_q <= data_out_d;
            err_q      <= err_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Memory contents survive reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[acc_index] <= acc_data;
        end
    end

    assign data_out   = data_out_q;
    assign mem_ready  = (state_q == DONE);
    assign addr_error = (state_q == DONE) && err_q;
    assign rd_count   = rd_count_q;
    assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder; three instances cover
// WAIT_STATES = 0, 2 and 3, each with its own stimulus and reset.
module tb_data_mem_responder;

    logic        clk;
    logic        reset_s [3];
    logic [31:0] addr_s  [3];
    logic [31:0] din_s   [3];
    logic        rd_s    [3];
    logic        wr_s    [3];
    logic [31:0] dout_s  [3];
    logic        ready_s [3];
    logic        err_s   [3];
    logic [15:0] rdc_s   [3];
    logic [15:0] wrc_s   [3];

    int totalChecks  = 0;
    int passedChecks = 0;

    data_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset_s[0]), .address_data(addr_s[0]), .data_in(din_s[0]),
        .MemRead(rd_s[0]), .MemWrite(wr_s[0]), .data_out(dout_s[0]), .mem_ready(ready_s[0]),
        .addr_error(err_s[0]), .rd_count(rdc_s[0]), .wr_count(wrc_s[0]));

    data_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(2)) dut1 (
        .clk(clk), .reset(reset_s[1]), .address_data(addr_s[1]), .data_in(din_s[1]),
        .MemRead(rd_s[1]), .MemWrite(wr_s[1]), .data_out(dout_s[1]), .mem_ready(ready_s[1]),
        .addr_error(err_s[1]), .rd_count(rdc_s[1]), .wr_count(wrc_s[1]));

    data_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(3)) dut2 (
        .clk(clk), .reset(reset_s[2]), .address_data(addr_s[2]), .data_in(din_s[2]),
        .MemRead(rd_s[2]), .MemWrite(wr_s[2]), .data_out(dout_s[2]), .mem_ready(ready_s[2]),
        .addr_error(err_s[2]), .rd_count(rdc_s[2]), .wr_count(wrc_s[2]));

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends even if something stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        else
            passedChecks++;
    endtask

    // Drives one unit's request inputs; called at a falling edge
    task automatic applyStimulus(input int u, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] din);
        rd_s[u]   = rd;
        wr_s[u]   = wr;
        addr_s[u] = addr;
        din_s[u]  = din;
    endtask

    // Waits (bounded) for mem_ready; lat is the falling-edge count, -1 on timeout
    task automatic waitReady(input int u, output int lat, output logic err, output logic [31:0] dout);
        lat  = -1;
        err  = 1'b0;
        dout = 32'd0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ready_s[u]) begin
                lat  = c;
                err  = err_s[u];
                dout = dout_s[u];
                break;
            end
        end
    endtask

    // Full access: request, wait for completion, drop request, let the FSM return to IDLE
    task automatic doAccess(input int u, input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] din, output int lat, output logic err,
                            output logic [31:0] dout);
        applyStimulus(u, rd, wr, addr, din);
        waitReady(u, lat, err, dout);
        applyStimulus(u, 1'b0, 1'b0, addr, din);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int          lat;
        int          pulses;
        int          first;
        logic        e;
        logic [31:0] d;

        for (int i = 0; i < 3; i++) begin
            reset_s[i] = 1'b1;
            applyStimulus(i, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst_dout", dout_s[0], 32'd0);
        checkOutput("rst_ready", ready_s[0], 32'd0);
        checkOutput("rst_err", err_s[0], 32'd0);
        checkOutput("rst_rdc", rdc_s[0], 32'd0);
        checkOutput("rst_wrc", wrc_s[0], 32'd0);
        for (int i = 0; i < 3; i++) reset_s[i] = 1'b0;
        @(negedge clk);

        // Zero wait states: write then read back
        doAccess(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, e, d);
        checkOutput("w0_lat", lat, 32'd1);
        checkOutput("w0_err", e, 32'd0);
        checkOutput("w0_wrc", wrc_s[0], 32'd1);
        doAccess(0, 1'b1, 1'b0, 32'h10, 32'd0, lat, e, d);
        checkOutput("r0_lat", lat, 32'd1);
        checkOutput("r0_data", d, 32'hDEADBEEF);
        checkOutput("r0_hold", dout_s[0], 32'hDEADBEEF);
        checkOutput("r0_rdc", rdc_s[0], 32'd1);
        checkOutput("r0_err_idle", err_s[0], 32'd0);
        doAccess(0, 1'b0, 1'b1, 32'h0, 32'h11111111, lat, e, d);
        checkOutput("w0b_wrc", wrc_s[0], 32'd2);

        // Address errors
        doAccess(0, 1'b1, 1'b0, 32'h12, 32'd0, lat, e, d);
        checkOutput("mis_err", e, 32'd1);
        checkOutput("mis_data", d, 32'd0);
        checkOutput("mis_rdc", rdc_s[0], 32'd1);
        checkOutput("mis_wrc", wrc_s[0], 32'd2);
        checkOutput("mis_err_idle", err_s[0], 32'd0);
        doAccess(0, 1'b1, 1'b0, 32'h400, 32'd0, lat, e, d);
        checkOutput("oor_err", e, 32'd1);
        checkOutput("oor_data", d, 32'd0);
        checkOutput("oor_rdc", rdc_s[0], 32'd1);
        doAccess(0, 1'b1, 1'b0, 32'h0, 32'd0, lat, e, d);
        checkOutput("r_m0_data", d, 32'h11111111);
        checkOutput("r_m0_rdc", rdc_s[0], 32'd2);
        doAccess(0, 1'b0, 1'b1, 32'h400, 32'hBAD0BAD0, lat, e, d);
        checkOutput("oorw_err", e, 32'd1);
        checkOutput("oorw_dout", d, 32'h11111111);
        checkOutput("oorw_wrc", wrc_s[0], 32'd2);
        doAccess(0, 1'b1, 1'b0, 32'h0, 32'd0, lat, e, d);
        checkOutput("m0_intact", d, 32'h11111111);
        checkOutput("m0_rdc", rdc_s[0], 32'd3);

        // Read and write together: write wins
        doAccess(0, 1'b1, 1'b1, 32'h20, 32'h5, lat, e, d);
        checkOutput("rw_err", e, 32'd0);
        checkOutput("rw_dout", d, 32'h11111111);
        checkOutput("rw_wrc", wrc_s[0], 32'd3);
        checkOutput("rw_rdc", rdc_s[0], 32'd3);
        doAccess(0, 1'b1, 1'b0, 32'h20, 32'd0, lat, e, d);
        checkOutput("rw_readback", d, 32'h5);

        // Two wait states: latency and held level request served once
        doAccess(1, 1'b0, 1'b1, 32'h10, 32'hCAFE0002, lat, e, d);
        checkOutput("w2_lat", lat, 32'd3);
        checkOutput("w2_wrc", wrc_s[1], 32'd1);
        applyStimulus(1, 1'b1, 1'b0, 32'h10, 32'd0);
        pulses = 0;
        first  = -1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (ready_s[1]) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        checkOutput("held_pulses", pulses, 32'd1);
        checkOutput("held_first", first, 32'd3);
        checkOutput("held_data", dout_s[1], 32'hCAFE0002);
        checkOutput("held_rdc", rdc_s[1], 32'd1);
        applyStimulus(1, 1'b0, 1'b0, 32'h10, 32'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("held_after_rdc", rdc_s[1], 32'd1);

        // Inputs changed during WAIT are ignored
        doAccess(1, 1'b0, 1'b1, 32'h34, 32'hA5A5A5A5, lat, e, d);
        applyStimulus(1, 1'b0, 1'b1, 32'h30, 32'h77);
        @(negedge clk);
        applyStimulus(1, 1'b0, 1'b1, 32'h34, 32'h99);
        waitReady(1, lat, e, d);
        checkOutput("latch_lat", lat, 32'd2);
        applyStimulus(1, 1'b0, 1'b0, 32'h34, 32'h99);
        @(negedge clk);
        @(negedge clk);
        checkOutput("latch_wrc", wrc_s[1], 32'd3);
        doAccess(1, 1'b1, 1'b0, 32'h30, 32'd0, lat, e, d);
        checkOutput("latch_m30", d, 32'h77);
        doAccess(1, 1'b1, 1'b0, 32'h34, 32'd0, lat, e, d);
        checkOutput("latch_m34", d, 32'hA5A5A5A5);

        // Three wait states: reset during WAIT aborts the write
        doAccess(2, 1'b0, 1'b1, 32'h40, 32'h12345678, lat, e, d);
        checkOutput("w3_lat", lat, 32'd4);
        doAccess(2, 1'b1, 1'b0, 32'h40, 32'd0, lat, e, d);
        checkOutput("w3_rd", d, 32'h12345678);
        applyStimulus(2, 1'b0, 1'b1, 32'h40, 32'hFFFF0000);
        @(negedge clk);
        @(negedge clk);
        reset_s[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort_dout", dout_s[2], 32'd0);
        checkOutput("abort_ready", ready_s[2], 32'd0);
        checkOutput("abort_wrc", wrc_s[2], 32'd0);
        checkOutput("abort_rdc", rdc_s[2], 32'd0);
        reset_s[2] = 1'b0;
        doAccess(2, 1'b1, 1'b0, 32'h40, 32'd0, lat, e, d);
        checkOutput("post_rst_lat", lat, 32'd4);
        checkOutput("post_rst_data", d, 32'h12345678);
        checkOutput("post_rst_rdc", rdc_s[2], 32'd1);
        checkOutput("post_rst_wrc", wrc_s[2], 32'd0);

        // Write counter saturation, starting just below the ceiling
        force dut0.wr_count_q = 16'hFFFE;
        @(negedge clk);
        release dut0.wr_count_q;
        doAccess(0, 1'b0, 1'b1, 32'h24, 32'h1, lat, e, d);
        checkOutput("sat_reach", wrc_s[0], 32'hFFFF);
        doAccess(0, 1'b0, 1'b1, 32'h28, 32'h2, lat, e, d);
        checkOutput("sat_hold", wrc_s[0], 32'hFFFF);
        checkOutput("sat_rdc", rdc_s[0], 32'd4);

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
